// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame draw/wait/erase/update sequencer for the running-man game,
// with pause, latched game-over halt and restart.
module frame_sequencer #(
    parameter int NUM_SPRITES = 2,
    parameter int FRAME_CNT_W = 4,
    parameter int FRAME_WAIT  = 14,
    localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   bg_done,
    input  logic                   spr_done,
    input  logic                   erase_done,
    input  logic [FRAME_CNT_W-1:0] frame_count,
    input  logic                   pause,
    input  logic                   game_over,
    input  logic                   restart,
    output logic                   draw_bg,
    output logic                   ld_obj,
    output logic                   spr_draw,
    output logic [SEL_W-1:0]       spr_sel,
    output logic                   erase,
    output logic                   update,
    output logic                   frame_cnt_clr_n,
    output logic                   write_en,
    output logic                   halted
);
    typedef enum logic [2:0] {
        S_BG, S_LOAD, S_SPR, S_WAIT, S_CLR, S_ERASE, S_UPD, S_HALT
    } state_t;

    localparam logic [SEL_W-1:0]       LAST   = SEL_W'(NUM_SPRITES - 1);
    localparam logic [FRAME_CNT_W-1:0] WAIT_V = FRAME_CNT_W'(FRAME_WAIT);

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic             go_q;

    // go_q is only consulted after the last sprite, so the collision frame is drawn in full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_BG;
            sel_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            if (game_over && state_q != S_HALT) go_q <= 1'b1;
            case (state_q)
                S_BG:    if (bg_done) state_q <= S_LOAD;
                S_LOAD:  begin
                    state_q <= S_SPR;
                    sel_q   <= '0;
                end
                S_SPR:   if (spr_done) begin
                    if (sel_q < LAST) sel_q <= sel_q + 1'b1;
                    else state_q <= go_q ? S_HALT : S_WAIT;
                end
                S_WAIT:  if (frame_count >= WAIT_V && !pause) state_q <= S_CLR;
                S_CLR:   state_q <= S_ERASE;
                S_ERASE: if (erase_done) state_q <= S_UPD;
                S_UPD:   state_q <= S_LOAD;
                S_HALT:  if (restart) begin
                    state_q <= S_BG;
                    go_q    <= 1'b0;
                end
                default: state_q <= S_BG;
            endcase
        end
    end

    assign draw_bg         = state_q == S_BG;
    assign ld_obj          = state_q == S_LOAD;
    assign spr_draw        = state_q == S_SPR;
    assign spr_sel         = sel_q;
    assign erase           = state_q == S_ERASE;
    assign update          = state_q == S_UPD;
    assign frame_cnt_clr_n = state_q != S_CLR;
    assign write_en        = draw_bg | spr_draw | erase;
    assign halted          = state_q == S_HALT;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of frame_sequencer with 2 sprites (main) and 3 sprites.
module tb_frame_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic bg_done = 0, spr_done = 0, erase_done = 0, pause = 0, game_over = 0, restart = 0;
    logic [3:0] frame_count = 4'd0;
    logic draw_bg, ld_obj, spr_draw, erase, update, frame_cnt_clr_n, write_en, halted;
    logic [0:0] spr_sel;
    logic bg3 = 0, spr3 = 0;
    logic [3:0] fc3 = 4'd0;
    logic draw_bg3, ld_obj3, spr_draw3, erase3, update3, clr3, we3, halted3;
    logic [1:0] spr_sel3;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    frame_sequencer u0 (
        .clk(clk), .reset_n(reset_n), .bg_done(bg_done), .spr_done(spr_done),
        .erase_done(erase_done), .frame_count(frame_count), .pause(pause),
        .game_over(game_over), .restart(restart), .draw_bg(draw_bg), .ld_obj(ld_obj),
        .spr_draw(spr_draw), .spr_sel(spr_sel), .erase(erase), .update(update),
        .frame_cnt_clr_n(frame_cnt_clr_n), .write_en(write_en), .halted(halted)
    );

    frame_sequencer #(.NUM_SPRITES(3)) u1 (
        .clk(clk), .reset_n(reset_n), .bg_done(bg3), .spr_done(spr3),
        .erase_done(1'b0), .frame_count(fc3), .pause(1'b0),
        .game_over(1'b0), .restart(1'b0), .draw_bg(draw_bg3), .ld_obj(ld_obj3),
        .spr_draw(spr_draw3), .spr_sel(spr_sel3), .erase(erase3), .update(update3),
        .frame_cnt_clr_n(clr3), .write_en(we3), .halted(halted3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // packs the main DUT's one-hot outputs: {draw_bg,ld_obj,spr_draw,erase,update,clr_n,write_en,halted}
    function automatic logic [7:0] outs();
        return {draw_bg, ld_obj, spr_draw, erase, update, frame_cnt_clr_n, write_en, halted};
    endfunction

    localparam logic [7:0] O_BG = 8'b1000_0110, O_LOAD = 8'b0100_0100, O_SPR = 8'b0010_0110,
                           O_IDLE = 8'b0000_0100, O_CLR = 8'b0000_0000, O_ERASE = 8'b0001_0110,
                           O_UPD = 8'b0000_1100, O_HALT = 8'b0000_0101;

    // drives the main DUT from LOAD-bound start through both sprites
    task automatic sprite_pass(input logic go_at_last, input logic [7:0] exp_end, input string tag);
        chk({tag, "_spr0"}, {outs(), 7'd0, spr_sel}, {O_SPR, 8'd0});
        spr_done = 1;
        tick();
        chk({tag, "_spr1"}, {outs(), 7'd0, spr_sel}, {O_SPR, 8'd1});
        game_over = go_at_last;
        tick();
        spr_done = 0;
        game_over = 0;
        chk({tag, "_end"}, outs(), exp_end);
    endtask

    task automatic wait_to_load(input string tag);
        pause = 0;
        frame_count = 4'd15;
        tick();
        chk({tag, "_clr"}, outs(), O_CLR);
        tick();
        chk({tag, "_erase"}, outs(), O_ERASE);
        erase_done = 1;
        tick();
        erase_done = 0;
        chk({tag, "_upd"}, outs(), O_UPD);
        tick();
        chk({tag, "_load"}, outs(), O_LOAD);
        tick();
    endtask

    initial begin
        #2;
        chk("rst_outs", outs(), O_BG);
        chk("rst_sel", spr_sel, 0);
        tick();
        chk("rst_hold", outs(), O_BG);
        #3 reset_n = 1;
        tick();
        chk("bg_wait", outs(), O_BG);

        // three-sprite channel iteration
        bg3 = 1;
        tick();
        bg3 = 0;
        chk("n3_load", ld_obj3, 1);
        tick();
        chk("n3_sel0", {spr_draw3, spr_sel3}, 3'b100);
        for (int i = 1; i <= 3; i++) begin
            spr3 = 1;
            tick();
            spr3 = 0;
            if (i < 3) chk($sformatf("n3_sel%0d", i), {spr_draw3, spr_sel3}, {1'b1, 2'(i)});
            else chk("n3_wait", {spr_draw3, we3, clr3, halted3}, 4'b0010);
            tick(3);
        end
        chk("n3_wait_hold", {spr_draw3, we3, ld_obj3}, 3'b000);

        // default DUT: background, load, sprites
        erase_done = 1;
        spr_done = 1;
        tick();
        chk("bg_ignore", outs(), O_BG);
        erase_done = 0;
        spr_done = 0;
        bg_done = 1;
        tick();
        bg_done = 0;
        chk("load", outs(), O_LOAD);
        tick();
        pause = 1;
        frame_count = 4'd14;
        erase_done = 1;
        tick();
        erase_done = 0;
        chk("spr_ignore", {outs(), 7'd0, spr_sel}, {O_SPR, 8'd0});
        sprite_pass(1'b0, O_IDLE, "p1");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("pause%0d", i), outs(), O_IDLE);
        end
        pause = 0;
        frame_count = 4'd13;
        tick();
        chk("below_wait", outs(), O_IDLE);
        frame_count = 4'd15;
        tick();
        chk("overshoot_clr", outs(), O_CLR);
        tick();
        chk("erase", outs(), O_ERASE);
        tick(2);
        chk("erase_hold", outs(), O_ERASE);
        erase_done = 1;
        tick();
        erase_done = 0;
        chk("update", outs(), O_UPD);
        tick();
        chk("reload", outs(), O_LOAD);
        tick();

        // game over during WAIT halts after the next full pass
        pause = 1;
        sprite_pass(1'b0, O_IDLE, "p2");
        game_over = 1;
        tick();
        game_over = 0;
        chk("go_wait", outs(), O_IDLE);
        wait_to_load("go");
        sprite_pass(1'b0, O_HALT, "p3");
        game_over = 1;
        tick(2);
        game_over = 0;
        chk("halt_go", outs(), O_HALT);
        restart = 1;
        tick();
        restart = 0;
        chk("restart", outs(), O_BG);
        bg_done = 1;
        tick(2);
        bg_done = 0;
        pause = 1;
        sprite_pass(1'b1, O_IDLE, "sim1");
        wait_to_load("sim1");
        sprite_pass(1'b0, O_HALT, "sim1b");

        // restart beats game_over in HALT
        restart = 1;
        game_over = 1;
        tick();
        restart = 0;
        game_over = 0;
        chk("sim2_bg", outs(), O_BG);
        bg_done = 1;
        tick(2);
        bg_done = 0;
        pause = 1;
        sprite_pass(1'b0, O_IDLE, "sim2");
        wait_to_load("sim2");
        sprite_pass(1'b0, O_IDLE, "sim2b");

        // async reset mid-ERASE
        pause = 0;
        tick(2);
        chk("pre_rst_erase", {outs(), 7'd0, spr_sel}, {O_ERASE, 8'd1});
        #3 reset_n = 0;
        #1;
        chk("async_rst", {outs(), 7'd0, spr_sel}, {O_BG, 8'd0});
        #2 reset_n = 1;
        tick();
        chk("post_rst", outs(), O_BG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
